datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Control FSM that drives the existing register-file/shifter/ALU datapath: readnum, writenum, vsel, write, loada, loadb, asel, bsel, shift, ALUop, loadc, loads.
- Replaces hand-driven switch control. Accepts one 16-bit instruction per start handshake, decodes it, and sequences the datapath control cycle by cycle.
- Sits between the instruction source (switches now, instruction register later) and the datapath.

Parameters:
- DATA_W, 16, datapath word width; also the width of datapath_in.
- REG_W, 3, register-number width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- s  in  1  start; sampled only in WAIT
- instr  in  16  instruction; captured when s is accepted
- w  out  1  idle/ready; high only in WAIT
- err  out  1  one-cycle pulse on an illegal opcode
- readnum  out  REG_W  register-file read select
- writenum  out  REG_W  register-file write select
- write  out  1  register-file write enable
- vsel  out  1  writeback select: 1 = datapath_in, 0 = C
- datapath_in  out  DATA_W  sign-extended imm8
- loada, loadb, loadc, loads  out  1 each  pipeline and status register enables
- asel, bsel  out  1 each  1 = force the ALU operand to 0 (A) or to datapath_in (B)
- shift  out  2  shifter op
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B

Behaviour:
- Instruction fields (latched instr):
  - opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0]
  - datapath_in = {{8{imm8[7]}}, imm8}
- Legal encodings:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
  - Anything else is illegal.
- Output style: Moore. Every output is a function of the state register plus the latched instr only; no input feeds an output combinationally.
- Defaults: every enable is 0; readnum, writenum, shift, ALUop, asel, bsel, vsel are 0 unless a state below says otherwise.
- States:
  - WAIT: w=1. If s, latch instr and go to DECODE; otherwise stay.
  - DECODE: no enables. MOV imm -> WR_IMM. MOV reg or MVN -> GET_B. ADD, CMP or AND -> GET_A. Illegal -> WAIT with err=1 this cycle.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> EXEC.
  - EXEC: shift=sh. MOV reg: asel=1, ALUop=00. Others: ALUop=op. CMP: loads=1, loadc=0 -> WAIT. Otherwise: loadc=1 -> WR_REG.
  - WR_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
  - WR_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- Latency (counted from the edge that accepts s until w is high again):
  - MOV imm: 3 cycles
  - MOV reg or MVN: 5
  - CMP: 5
  - ADD or AND: 6
- s outside WAIT is ignored. instr changes after acceptance have no effect.
- s held high through WAIT re-arms immediately, giving back-to-back instructions.
- reset:
  - Forces WAIT and clears the latched instr to 0 on the next edge, from any state, including mid-sequence.
  - No write occurs in the cycle after reset.
  - Post-reset outputs: w=1, all others 0, datapath_in=0.
- Illegal opcode: err is high for exactly the DECODE cycle. No enables are asserted and the register file is untouched.

Decomposition:
- Package seq_pkg holds:
  - the state enum (WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM)
  - opcode/op localparams
  - ALUop and shift code constants
- One sub-module, instr_decoder: combinational field extraction, sign extension and legality flag. Shared later by the CPU top.

Test Plan:
- Reset: reset high for 2 edges mid-EXEC of an ADD -> w=1, write never asserted, all enables 0.
- MOV imm: instr=0xD007 (MOV R0,#7), s pulse -> WR_IMM 2 cycles later with writenum=0, vsel=1, write=1, datapath_in=0x0007. Then 0xD5FE -> writenum=5, datapath_in=0xFFFE.
- ADD: instr=0xA148 (ADD R2,R1,R0 LSL#1) -> GET_A readnum=1 loada; GET_B readnum=0 loadb; EXEC shift=01 ALUop=00 loadc; WR_REG writenum=2 write. w high 6 cycles after acceptance. Checked against a datapath model with R0=R1=7: R2=21.
- CMP and MOV reg:
  - 0xA900 -> EXEC with loads=1 and loadc=0; no write; back to WAIT after 5 cycles.
  - 0xC061 -> asel=1, ALUop=00, writenum=3.
- Illegal opcode: 0x0000 -> err high exactly one cycle, no enables, w after 2 cycles.
- Back-to-back: s held high across two instructions -> second accepted in the cycle w returns; instr changed during the first sequence is ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the datapath sequencer: FSM states, instruction
// opcode/op fields, ALU operations and shifter codes.
package seq_pkg;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GET_A,
    GET_B,
    EXEC,
    WR_REG,
    WR_IMM
  } state_e;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction field extraction, imm8 sign extension and
// legality/class flags; reusable by the future CPU top.
module instr_decoder
  import seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [1:0]         op_o,
  output logic [REG_W-1:0]   rn_o,
  output logic [REG_W-1:0]   rd_o,
  output logic [REG_W-1:0]   rm_o,
  output logic [1:0]         sh_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic               legal_o,
  output logic               is_mov_imm_o,
  output logic               is_mov_reg_o,
  output logic               is_cmp_o,
  output logic               is_mvn_o
);

  logic [2:0] opcode;

  assign opcode = instr_i[15:13];
  assign op_o   = instr_i[12:11];
  assign rn_o   = instr_i[8 +: REG_W];
  assign rd_o   = instr_i[5 +: REG_W];
  assign sh_o   = instr_i[4:3];
  assign rm_o   = instr_i[0 +: REG_W];
  assign imm_o  = {{(DATA_W-8){instr_i[7]}}, instr_i[7:0]};

  assign is_mov_imm_o = (opcode == OPC_MOV) && (op_o == OP_MOV_IMM);
  assign is_mov_reg_o = (opcode == OPC_MOV) && (op_o == OP_MOV_REG);
  assign is_cmp_o     = (opcode == OPC_ALU) && (op_o == OP_CMP);
  assign is_mvn_o     = (opcode == OPC_ALU) && (op_o == OP_MVN);
  // Every op value under the ALU opcode is defined; only two MOV forms are.
  assign legal_o      = is_mov_imm_o || is_mov_reg_o || (opcode == OPC_ALU);

endmodule

// File: rtl/datapath_sequencer.sv
// Moore control FSM that takes one instruction per start handshake and
// sequences the register-file/shifter/ALU datapath enables cycle by cycle.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [INSTR_W-1:0] instr,
  output logic               w,
  output logic               err,
  output logic [REG_W-1:0]   readnum,
  output logic [REG_W-1:0]   writenum,
  output logic               write,
  output logic               vsel,
  output logic [DATA_W-1:0]  datapath_in,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic               bsel,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic [1:0]       op, sh;
  logic [REG_W-1:0] rn, rd, rm;
  logic             legal, is_mov_imm, is_mov_reg, is_cmp, is_mvn;

  instr_decoder #(.DATA_W(DATA_W), .REG_W(REG_W)) u_dec (
    .instr_i      (instr_q),
    .op_o         (op),
    .rn_o         (rn),
    .rd_o         (rd),
    .rm_o         (rm),
    .sh_o         (sh),
    .imm_o        (datapath_in),
    .legal_o      (legal),
    .is_mov_imm_o (is_mov_imm),
    .is_mov_reg_o (is_mov_reg),
    .is_cmp_o     (is_cmp),
    .is_mvn_o     (is_mvn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    case (state_q)
      WAIT: begin
        w = 1'b1;
        if (s) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!legal) begin
          err     = 1'b1;
          state_d = WAIT;
        end else if (is_mov_imm) begin
          state_d = WR_IMM;
        end else if (is_mov_reg || is_mvn) begin
          state_d = GET_B;
        end else begin
          state_d = GET_A;
        end
      end
      GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = GET_B;
      end
      GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        shift = sh;
        // MOV reg reuses the adder with A forced to zero: C = 0 + shifted Rm.
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = WR_REG;
        end
      end
      WR_REG: begin
        writenum = rd;
        write    = 1'b1;
        state_d  = WAIT;
      end
      WR_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
        state_d  = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural datapath driven by the DUT's
// control outputs is compared against an instruction-level register model.
module tb_datapath_sequencer;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, s;
  logic [15:0]       instr;
  logic              w, err, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [REG_W-1:0]  readnum, writenum;
  logic [DATA_W-1:0] datapath_in;
  logic [1:0]        shift, ALUop;

  datapath_sequencer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .datapath_in(datapath_in), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
  );

  typedef struct packed {
    logic w, err;
    logic [2:0] rdn, wrn;
    logic wr, vsel;
    logic [15:0] dpin;
    logic la, lb, lc, ls, asel, bsel;
    logic [1:0] sh, alu;
  } snap_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t t;
    t.w = w; t.err = err; t.rdn = readnum; t.wrn = writenum; t.wr = write;
    t.vsel = vsel; t.dpin = datapath_in; t.la = loada; t.lb = loadb;
    t.lc = loadc; t.ls = loads; t.asel = asel; t.bsel = bsel;
    t.sh = shift; t.alu = ALUop;
    return t;
  endfunction

  function automatic logic [15:0] shf(input logic [1:0] op, input logic [15:0] v);
    case (op)
      2'd0: return v;
      2'd1: return {v[14:0], 1'b0};
      2'd2: return {1'b0, v[15:1]};
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  function automatic logic [15:0] dp_alu(input logic [1:0] op, input logic as, input logic bs,
                                         input logic [1:0] sh, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] imm);
    logic [15:0] x, y;
    x = as ? 16'h0 : a;
    y = bs ? imm : shf(sh, b);
    case (op)
      2'd0: return x + y;
      2'd1: return x - y;
      2'd2: return x & y;
      default: return ~y;
    endcase
  endfunction

  // Behavioural datapath obeying whatever control the DUT presents.
  logic [15:0] dp_r[8];
  logic [15:0] dp_a, dp_b, dp_c;
  logic        dp_z, mdl_clr;

  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 8; i++) dp_r[i] <= '0;
      dp_a <= '0; dp_b <= '0; dp_c <= '0; dp_z <= 1'b0;
    end else begin
      if (write) dp_r[writenum] <= vsel ? datapath_in : dp_c;
      if (loada) dp_a <= dp_r[readnum];
      if (loadb) dp_b <= dp_r[readnum];
      if (loadc) dp_c <= dp_alu(ALUop, asel, bsel, shift, dp_a, dp_b, datapath_in);
      if (loads) dp_z <= (dp_alu(ALUop, asel, bsel, shift, dp_a, dp_b, datapath_in) == 16'h0);
    end
  end

  // Instruction-level reference: architectural effect plus expected timing.
  logic [15:0] ex_r[8];
  logic        ex_z;

  task automatic isa(input logic [15:0] ins, output int lat, output int nwr, output int nerr);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sv;
    logic [15:0] b, diff;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd = ins[7:5]; sv = ins[4:3]; rm = ins[2:0];
    b = shf(sv, ex_r[rm]);
    lat = 2; nwr = 0; nerr = 0;
    if (opc == 3'b110 && op == 2'b10) begin
      ex_r[rn] = {{8{ins[7]}}, ins[7:0]}; lat = 3; nwr = 1;
    end else if (opc == 3'b110 && op == 2'b00) begin
      ex_r[rd] = b; lat = 5; nwr = 1;
    end else if (opc == 3'b101) begin
      case (op)
        2'd0: begin ex_r[rd] = ex_r[rn] + b; lat = 6; nwr = 1; end
        2'd1: begin diff = ex_r[rn] - b; ex_z = (diff == 16'h0); lat = 5; end
        2'd2: begin ex_r[rd] = ex_r[rn] & b; lat = 6; nwr = 1; end
        default: begin ex_r[rd] = ~b; lat = 5; nwr = 1; end
      endcase
    end else begin
      nerr = 1;
    end
  endtask

  snap_t tr[32];
  int    last_lat, last_wr, last_err;

  task automatic wait_idle();
    int k = 0;
    while (!w && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (k == 20) check("wait_idle_timeout", 32'(w), 32'd1);
  endtask

  task automatic run(input logic [15:0] ins, input string tag);
    int n, el, ew, ee;
    wait_idle();
    instr = ins; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    instr = 16'($urandom);
    n = 0; last_wr = 0; last_err = 0;
    while (!w && n < 20) begin
      tr[n] = snap();
      if (err) last_err++;
      if (write) last_wr++;
      n++;
      @(posedge clk); #1;
    end
    last_lat = n + 1;
    isa(ins, el, ew, ee);
    check({tag, "_latency"}, 32'(last_lat), 32'(el));
    check({tag, "_writes"}, 32'(last_wr), 32'(ew));
    check({tag, "_err"}, 32'(last_err), 32'(ee));
    for (int i = 0; i < 8; i++) check($sformatf("%s_R%0d", tag, i), 32'(dp_r[i]), 32'(ex_r[i]));
    check({tag, "_Z"}, 32'(dp_z), 32'(ex_z));
  endtask

  initial begin
    int wseen, el, ew, ee;
    logic [15:0] ins;
    reset = 1'b1; s = 1'b0; instr = 16'hFFFF; mdl_clr = 1'b1;
    for (int i = 0; i < 8; i++) ex_r[i] = '0;
    ex_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_w", 32'(w), 32'd1);
    check("reset_enables", {27'd0, write, loada, loadb, loadc, loads}, 32'd0);
    check("reset_selects", {16'd0, err, readnum, writenum, shift, ALUop, asel, bsel, vsel}, 32'd0);
    check("reset_dpin", 32'(datapath_in), 32'd0);
    reset = 1'b0; mdl_clr = 1'b0;

    run(16'hD007, "mov_r0_7");
    check("movimm_decode_nowrite", 32'(tr[0].wr), 32'd0);
    check("movimm_wrn", 32'(tr[1].wrn), 32'd0);
    check("movimm_vsel_write", {30'd0, tr[1].vsel, tr[1].wr}, 32'd3);
    check("movimm_dpin", 32'(tr[1].dpin), 32'h0007);
    run(16'hD5FE, "mov_r5_neg2");
    check("movneg_wrn", 32'(tr[1].wrn), 32'd5);
    check("movneg_dpin", 32'(tr[1].dpin), 32'hFFFE);
    run(16'hD107, "mov_r1_7");

    run(16'hA148, "add");
    check("add_geta", {28'd0, tr[1].rdn, tr[1].la}, {28'd0, 3'd1, 1'b1});
    check("add_getb", {28'd0, tr[2].rdn, tr[2].lb}, {28'd0, 3'd0, 1'b1});
    check("add_exec", {27'd0, tr[3].sh, tr[3].alu, tr[3].lc}, {27'd0, 2'b01, 2'b00, 1'b1});
    check("add_wrreg", {28'd0, tr[4].wrn, tr[4].wr}, {28'd0, 3'd2, 1'b1});
    check("add_lat6", 32'(last_lat), 32'd6);
    check("add_R2_21", 32'(dp_r[2]), 32'd21);

    run(16'hA900, "cmp");
    check("cmp_exec_loads_loadc", {30'd0, tr[3].ls, tr[3].lc}, 32'd2);
    check("cmp_nowrite", 32'(last_wr), 32'd0);
    check("cmp_lat5", 32'(last_lat), 32'd5);
    check("cmp_Z", 32'(dp_z), 32'd1);

    run(16'hC061, "movreg");
    check("movreg_exec", {29'd0, tr[2].asel, tr[2].alu}, {29'd0, 1'b1, 2'b00});
    check("movreg_wrn", 32'(tr[3].wrn), 32'd3);
    check("movreg_R3", 32'(dp_r[3]), 32'd7);

    run(16'h0000, "illegal");
    check("illegal_err_decode", 32'(tr[0].err), 32'd1);
    check("illegal_no_enables", {27'd0, tr[0].wr, tr[0].la, tr[0].lb, tr[0].lc, tr[0].ls}, 32'd0);
    check("illegal_lat2", 32'(last_lat), 32'd2);

    // Reset while an ADD R4,R1,R0 sits in EXEC.
    wait_idle();
    instr = 16'hA180; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_in_exec", 32'(loadc), 32'd1);
    reset = 1'b1; wseen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (write) wseen++;
    end
    check("rst_mid_w", 32'(w), 32'd1);
    check("rst_mid_enables", {27'd0, write, loada, loadb, loadc, loads}, 32'd0);
    check("rst_mid_dpin", 32'(datapath_in), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    if (write) wseen++;
    check("rst_mid_no_write", 32'(wseen), 32'd0);
    check("rst_mid_R4", 32'(dp_r[4]), 32'(ex_r[4]));

    // Back-to-back: s held high; instr changed during the first sequence.
    wait_idle();
    instr = 16'hD32A; s = 1'b1;
    @(posedge clk); #1;
    instr = 16'hD6FF;
    @(posedge clk); #1;
    check("b2b_first_wrn", 32'(writenum), 32'd3);
    check("b2b_first_dpin", 32'(datapath_in), 32'h002A);
    @(posedge clk); #1;
    check("b2b_w_back", 32'(w), 32'd1);
    @(posedge clk); #1;
    check("b2b_rearm", 32'(w), 32'd0);
    s = 1'b0; instr = 16'h0000;
    @(posedge clk); #1;
    check("b2b_second_wrn", 32'(writenum), 32'd6);
    check("b2b_second_dpin", 32'(datapath_in), 32'hFFFF);
    @(posedge clk); #1;
    check("b2b_done_w", 32'(w), 32'd1);
    isa(16'hD32A, el, ew, ee);
    isa(16'hD6FF, el, ew, ee);
    check("b2b_R3", 32'(dp_r[3]), 32'(ex_r[3]));
    check("b2b_R6", 32'(dp_r[6]), 32'(ex_r[6]));

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    ins = {3'b101, 13'($urandom)};
        2:       ins = {3'b110, 2'b10, 11'($urandom)};
        3:       ins = {3'b110, 2'b00, 11'($urandom)};
        default: ins = 16'($urandom);
      endcase
      run(ins, $sformatf("rnd%0d_%04h", t, ins));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
